cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Age-ordered arbiter that shares the two common data bus (CDB) writeback ports among the functional-unit result sources. It sits between the execute units and every CDB consumer (ROB, reservation stations, rename). Each cycle it grants the two oldest pending results, with age measured in ROB order from `rob_head`. Each source has a one-entry holding register with a valid/ready handshake, so a losing unit stalls instead of dropping its result.

## Interface
- `NUM_WB_SRC`, default 4: number of result sources (ALU0, ALU1, LSU, MUL/BRU).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush from commit.
- `rob_head`  in  TAG_WIDTH  current ROB head tag, the age reference.
- `fu_pkt[NUM_WB_SRC]`  in  writeback_packet_t  source result; `is_valid` acts as the request.
- `fu_rdy[NUM_WB_SRC]`  out  1  source may present a new packet this cycle.
- `cdb_port0`, `cdb_port1`  out  writeback_packet_t  registered CDB broadcasts; port0 always carries the older result.

## Operation
- Holding register per source i: `hold[i]` (packet) and `hold_v[i]`.
- `fu_rdy[i] = !rst && !flush && (!hold_v[i] || grant[i])`, where `grant[i]` is this cycle's grant.
- Handshake: transfer occurs when `fu_pkt[i].is_valid && fu_rdy[i]`. On that edge `hold[i]` loads the packet and `hold_v[i]` sets.
- If `grant[i]` is set and there is no transfer, `hold_v[i]` clears.
- A source must keep its packet stable while `fu_rdy[i]` is low.
- Age of a held entry = `(hold[i].dest_tag - rob_head)` mod ROB_ENTRIES, computed in TAG_WIDTH bits unsigned. Smaller age means older, and the modular subtraction handles wrap-around.
- Selection runs among entries with `hold_v` set:
  - oldest goes to port0; second-oldest goes to port1;
  - zero pending gives both ports invalid; one pending gives port0 only, and port1 is invalid.
- Equal ages cannot occur because ROB tags are unique. The tie-break is the lower source index, for determinism.
- `cdb_port0/1` register the selected packets. Unselected ports register `'0` (`is_valid = 0`).
- Starvation-free: the oldest pending result is always granted.
- Flush and reset have identical effect on the next edge: all `hold_v` clear, both CDB ports become `'0`, and any packet presented that cycle is discarded.

## Timing
- Latency: transfer at edge N, arbitration in cycle N+1, CDB valid in cycle N+2 (2 cycles).
- Throughput: one packet per source per cycle when granted, i.e. full streaming; 2 packets per cycle in aggregate.
- Reset values:
  - `hold_v` all 0;
  - `cdb_port0` and `cdb_port1` all-zero;
  - `fu_rdy` all 0 while `rst` or `flush` is high, then 1 on the first cycle after.
- Same-cycle grant plus new transfer on one source: the old entry broadcasts and the new entry is captured. There is no bubble.
- `rob_head` is sampled combinationally in the arbitration cycle.
- Reset or flush mid-operation: in-flight held results are lost by design, because the ROB is flushed too.

## Structure
- `writeback_packet_t`, `TAG_WIDTH`, and `ROB_ENTRIES` come from `uarch_pkg`.
- Add `NUM_WB_SRC` to `uarch_pkg`.
- Sub-module `wb_age_select`, purely combinational:
  - inputs: `hold_v`, the tags, `rob_head`;
  - outputs: two one-hot grant vectors plus valid bits for port0 and port1.
- `cdb_arbiter` owns the holding registers, the handshake, the CDB output registers, and flush/reset.

## Test plan
- Single result, `rob_head` = 0, FU0 tag 5 at cycle 0:
  - cycle 2: `cdb_port0` valid, tag 5; `cdb_port1` invalid;
  - `fu_rdy[0]` stays 1.
- Three results, `rob_head` = 2, FU0/FU1/FU2 tags 7/3/5 at cycle 0:
  - cycle 1: `fu_rdy[0]` = 0;
  - cycle 2: port0 = tag 3, port1 = tag 5;
  - cycle 3: port0 = tag 7.
- Wrap-around, ROB_ENTRIES = 16, `rob_head` = 14, FU1 tag 1 and FU3 tag 15: port0 = tag 15, port1 = tag 1.
- Streaming: FU0 presents tags 0..7 on consecutive cycles, other sources idle:
  - `fu_rdy[0]` remains 1;
  - port0 shows tags 0..7 on cycles 2..9.
- Flush while 3 holds are valid, with FU2 presenting tag 9 in the flush cycle:
  - next cycle: both ports invalid and all holds empty;
  - tag 9 never appears on the CDB.
- Reset asserted for 1 cycle mid-stream: all outputs return to reset values the next cycle, and normal acceptance resumes in the cycle after.

Source files
------------

// File: rtl/uarch_pkg.sv
// uarch_pkg: shared micro-architecture types and sizes for the writeback path
package uarch_pkg;
  localparam int TAG_WIDTH = 4;
  localparam int ROB_ENTRIES = 1 << TAG_WIDTH;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WB_SRC = 4;
  typedef struct packed {
    logic                  is_valid;
    logic [TAG_WIDTH-1:0]  dest_tag;
    logic [DATA_WIDTH-1:0] data;
  } writeback_packet_t;
  function automatic logic [TAG_WIDTH-1:0] age_of(input logic [TAG_WIDTH-1:0] tag, input logic [TAG_WIDTH-1:0] head);
    return tag - head;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-source handshake and CDB broadcast bundle
interface cdb_arbiter_if #(parameter int N = uarch_pkg::NUM_WB_SRC);
  import uarch_pkg::*;
  logic                 flush;
  logic [TAG_WIDTH-1:0] rob_head;
  writeback_packet_t    fu_pkt [N];
  logic [N-1:0]         fu_rdy;
  writeback_packet_t    cdb_port0;
  writeback_packet_t    cdb_port1;
  modport master (output flush, rob_head, fu_pkt, input fu_rdy, cdb_port0, cdb_port1);
  modport slave (input flush, rob_head, fu_pkt, output fu_rdy, cdb_port0, cdb_port1);
endinterface

// File: rtl/wb_age_select.sv
// wb_age_select: picks the two oldest held results by ROB age, lower index on ties
module wb_age_select import uarch_pkg::*; #(
  parameter int N = NUM_WB_SRC
) (
  input  logic [N-1:0]         hold_v,
  input  logic [TAG_WIDTH-1:0] tag [N],
  input  logic [TAG_WIDTH-1:0] rob_head,
  output logic [N-1:0]         grant0,
  output logic [N-1:0]         grant1,
  output logic                 valid0,
  output logic                 valid1
);
  localparam int RW = $clog2(N) + 1;
  logic [TAG_WIDTH-1:0] age [N];
  logic [RW-1:0] rank [N];
  always_comb begin
    for (int i = 0; i < N; i++) age[i] = age_of(tag[i], rob_head);
    for (int i = 0; i < N; i++) begin
      rank[i] = '0;
      for (int j = 0; j < N; j++)
        if (hold_v[j] && (age[j] < age[i] || (age[j] == age[i] && j < i))) rank[i] = rank[i] + RW'(1);
      grant0[i] = hold_v[i] && rank[i] == '0;
      grant1[i] = hold_v[i] && rank[i] == RW'(1);
    end
  end
  assign valid0 = |grant0;
  assign valid1 = |grant1;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: holds FU results and broadcasts the two oldest on the CDB ports
module cdb_arbiter import uarch_pkg::*; #(
  parameter int NUM_WB_SRC = uarch_pkg::NUM_WB_SRC
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);
  localparam int N = NUM_WB_SRC;
  writeback_packet_t hold_q [N];
  writeback_packet_t hold_d [N];
  logic [N-1:0] hold_v_q, hold_v_d, grant0, grant1, grant, xfer, rdy;
  logic [TAG_WIDTH-1:0] hold_tag [N];
  logic valid0, valid1, kill;
  writeback_packet_t sel0, sel1, cdb0_q, cdb0_d, cdb1_q, cdb1_d;
  always_comb begin
    for (int i = 0; i < N; i++) hold_tag[i] = hold_q[i].dest_tag;
  end
  wb_age_select #(.N(N)) u_sel (
    .hold_v(hold_v_q), .tag(hold_tag), .rob_head(bus.rob_head),
    .grant0(grant0), .grant1(grant1), .valid0(valid0), .valid1(valid1)
  );
  assign kill = rst || bus.flush;
  assign grant = grant0 | grant1;
  // a granted entry frees its slot this cycle, so the source can stream without a bubble
  always_comb begin
    sel0 = '0;
    sel1 = '0;
    for (int i = 0; i < N; i++) begin
      rdy[i] = !kill && (!hold_v_q[i] || grant[i]);
      xfer[i] = bus.fu_pkt[i].is_valid && rdy[i];
      hold_v_d[i] = !kill && (xfer[i] || (hold_v_q[i] && !grant[i]));
      hold_d[i] = xfer[i] ? bus.fu_pkt[i] : hold_q[i];
      if (grant0[i]) sel0 = hold_q[i];
      if (grant1[i]) sel1 = hold_q[i];
    end
    cdb0_d = (kill || !valid0) ? '0 : sel0;
    cdb1_d = (kill || !valid1) ? '0 : sel1;
  end
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    hold_v_q <= hold_v_d;
    cdb0_q <= cdb0_d;
    cdb1_q <= cdb1_d;
  end
  assign bus.fu_rdy = rdy;
  assign bus.cdb_port0 = cdb0_q;
  assign bus.cdb_port1 = cdb1_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a queue scoreboard checking CDB broadcasts
module tb_cdb_arbiter;
  import uarch_pkg::*;
  typedef struct {
    int                cyc;
    writeback_packet_t p0;
    writeback_packet_t p1;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  cdb_arbiter_if bus ();
  cdb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q [$];
  exp_t e;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic writeback_packet_t pk(input logic [3:0] t);
    writeback_packet_t p;
    p.is_valid = 1'b1;
    p.dest_tag = t;
    p.data = 32'hC0DE_0000 + 32'(t);
    return p;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic put(input int i, input logic [3:0] t);
    bus.fu_pkt[i] = pk(t);
  endtask
  task automatic idle();
    for (int i = 0; i < NUM_WB_SRC; i++) bus.fu_pkt[i] = '0;
  endtask
  task automatic expect_out(input int c, input writeback_packet_t a, input writeback_packet_t b);
    exp_q.push_back('{c, a, b});
  endtask
  always @(negedge clk) begin
    if (bus.cdb_port0.is_valid || bus.cdb_port1.is_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected port0=%h port1=%h cyc=%0d", bus.cdb_port0, bus.cdb_port1, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.p0 !== bus.cdb_port0 || e.p1 !== bus.cdb_port1) begin
          errors++;
          $display("FAIL cdb_out actual cyc=%0d p0=%h p1=%h expected cyc=%0d p0=%h p1=%h",
                   cyc, bus.cdb_port0, bus.cdb_port1, e.cyc, e.p0, e.p1);
        end
      end
    end
  end
  initial begin
    idle();
    bus.flush = 1'b0;
    bus.rob_head = '0;
    step(2);
    @(negedge clk);
    check("rst_rdy", 64'(bus.fu_rdy), 64'h0);
    check("rst_port0", 64'(bus.cdb_port0), 64'h0);
    check("rst_port1", 64'(bus.cdb_port1), 64'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 64'(bus.fu_rdy), 64'hF);
    step();
    put(0, 4'd5);
    expect_out(cyc + 2, pk(4'd5), '0);
    @(negedge clk);
    check("single_rdy_c0", 64'(bus.fu_rdy[0]), 64'h1);
    step();
    idle();
    @(negedge clk);
    check("single_rdy_c1", 64'(bus.fu_rdy[0]), 64'h1);
    step(4);
    bus.rob_head = 4'd2;
    put(0, 4'd7);
    put(1, 4'd3);
    put(2, 4'd5);
    expect_out(cyc + 2, pk(4'd3), pk(4'd5));
    expect_out(cyc + 3, pk(4'd7), '0);
    step();
    idle();
    @(negedge clk);
    check("three_rdy0_stall", 64'(bus.fu_rdy[0]), 64'h0);
    check("three_rdy1_granted", 64'(bus.fu_rdy[1]), 64'h1);
    step(4);
    bus.rob_head = 4'd14;
    put(1, 4'd1);
    put(3, 4'd15);
    expect_out(cyc + 2, pk(4'd15), pk(4'd1));
    step();
    idle();
    step(4);
    bus.rob_head = 4'd0;
    for (int k = 0; k < 8; k++) begin
      put(0, 4'(k));
      expect_out(cyc + 2, pk(4'(k)), '0);
      @(negedge clk);
      check("stream_rdy0", 64'(bus.fu_rdy[0]), 64'h1);
      step();
    end
    idle();
    step(4);
    put(0, 4'd1);
    put(1, 4'd2);
    put(2, 4'd3);
    step();
    idle();
    put(2, 4'd9);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_rdy", 64'(bus.fu_rdy), 64'h0);
    step();
    bus.flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush_port0", 64'(bus.cdb_port0), 64'h0);
    check("flush_port1", 64'(bus.cdb_port1), 64'h0);
    check("flush_holds_empty", 64'(bus.fu_rdy), 64'hF);
    step(4);
    put(0, 4'd10);
    put(1, 4'd11);
    step();
    rst = 1'b1;
    idle();
    put(0, 4'd12);
    @(negedge clk);
    check("midrst_rdy", 64'(bus.fu_rdy), 64'h0);
    step();
    rst = 1'b0;
    idle();
    put(0, 4'd13);
    expect_out(cyc + 2, pk(4'd13), '0);
    @(negedge clk);
    check("midrst_port0", 64'(bus.cdb_port0), 64'h0);
    check("midrst_port1", 64'(bus.cdb_port1), 64'h0);
    check("midrst_rdy_after", 64'(bus.fu_rdy), 64'hF);
    step();
    idle();
    step(5);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
